// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise logic stage: opcode constants and the
// per-bit logic function used by the datapath.
// Optional feature macro used by the top level: REDUCE_FLAGS_EN.
package bitwise_pkg;

    // Opcode encoding presented on i_Op
    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOTA  = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_XNOR  = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    // Single-bit logic operation; the top level applies it to every bit
    // position so the function stays independent of the operand width.
    function automatic logic bitop(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOTA:  r = ~a;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// Generic valid/ready payload register. One beat of storage; it accepts a
// new beat whenever it is empty or its current beat is leaving downstream,
// which gives full throughput when chained.
module pipe_reg_stage #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              load;

    assign load     = !valid_q || dn_ready;
    assign up_ready = load;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // Load/hold register: payload only changes when a real beat arrives so
    // the outputs stay stable while stalled or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else if (load) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/bitwise_logic_stage.sv
// Pipelined, handshaked bitwise logic unit. Stage 1 registers the logic-op
// result and the field base; stage 2 registers the result, the extracted
// field and the zero flag.
// Optional feature macro: REDUCE_FLAGS_EN adds registered reduction flags
// o_RedAnd/o_RedOr/o_RedXor of the stage-2 result.
module bitwise_logic_stage
    import bitwise_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int FIELD_W = 4,
    localparam int LSB_W   = $clog2(WIDTH)
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [WIDTH-1:0]   i_A,
    input  logic [WIDTH-1:0]   i_B,
    input  logic [2:0]         i_Op,
    input  logic [LSB_W-1:0]   i_Lsb,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [WIDTH-1:0]   o_Result,
    output logic [FIELD_W-1:0] o_Field,
`ifdef REDUCE_FLAGS_EN
    output logic               o_RedAnd,
    output logic               o_RedOr,
    output logic               o_RedXor,
`endif
    output logic               o_Zero
);

    localparam int S1_W = LSB_W + WIDTH;
`ifdef REDUCE_FLAGS_EN
    localparam int S2_W = WIDTH + FIELD_W + 4;
`else
    localparam int S2_W = WIDTH + FIELD_W + 1;
`endif
    // Only the zero flag resets high; everything else in stage 2 resets low.
    localparam logic [S2_W-1:0] S2_RESET = S2_W'(1) << (WIDTH + FIELD_W);

    logic [WIDTH-1:0]   op_result;
    logic [S1_W-1:0]    s1_in;
    logic [S1_W-1:0]    s1_data;
    logic               s1_valid;
    logic [LSB_W-1:0]   s1_lsb;
    logic [WIDTH-1:0]   s1_result;
    logic [WIDTH-1:0]   shifted;
    logic [FIELD_W-1:0] field;
    logic               zero;
    logic               s2_load;
    logic [S2_W-1:0]    s2_in;
    logic [S2_W-1:0]    s2_data;

    // Per-bit logic operation across the full operand width
    always_comb begin
        op_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            op_result[i] = bitop(i_Op, i_A[i], i_B[i]);
        end
    end

    assign s1_in = {i_Lsb, op_result};

    pipe_reg_stage #(
        .DATA_W    (S1_W),
        .RESET_VAL ('0)
    ) u_s1 (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .up_valid (i_Valid),
        .up_ready (o_Ready),
        .up_data  (s1_in),
        .dn_valid (s1_valid),
        .dn_ready (s2_load),
        .dn_data  (s1_data)
    );

    assign s1_lsb    = s1_data[S1_W-1:WIDTH];
    assign s1_result = s1_data[WIDTH-1:0];

    // Field extraction: a logical right shift zero-fills from the top, so a
    // field that runs past the MSB reads zeros instead of wrapping around.
    always_comb begin
        shifted = s1_result >> s1_lsb;
        field   = FIELD_W'(shifted);
        zero    = ~|s1_result;
    end

`ifdef REDUCE_FLAGS_EN
    assign s2_in = {^s1_result, |s1_result, &s1_result, zero, field, s1_result};
`else
    assign s2_in = {zero, field, s1_result};
`endif

    pipe_reg_stage #(
        .DATA_W    (S2_W),
        .RESET_VAL (S2_RESET)
    ) u_s2 (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .up_valid (s1_valid),
        .up_ready (s2_load),
        .up_data  (s2_in),
        .dn_valid (o_Valid),
        .dn_ready (i_Ready),
        .dn_data  (s2_data)
    );

    assign o_Result = s2_data[WIDTH-1:0];
    assign o_Field  = s2_data[WIDTH+FIELD_W-1:WIDTH];
    assign o_Zero   = s2_data[WIDTH+FIELD_W];
`ifdef REDUCE_FLAGS_EN
    assign o_RedAnd = s2_data[WIDTH+FIELD_W+1];
    assign o_RedOr  = s2_data[WIDTH+FIELD_W+2];
    assign o_RedXor = s2_data[WIDTH+FIELD_W+3];
`endif

endmodule

// File: tb/tb_bitwise_logic_stage.sv
// Self-checking bench for bitwise_logic_stage (WIDTH=8, FIELD_W=4).
// A queue of expected beats is filled on every input handshake and compared
// against the outputs every cycle; readiness and output validity come from
// occupancy and beat age rather than from the pipeline's register structure.
module tb_bitwise_logic_stage;

    localparam int WIDTH   = 8;
    localparam int FIELD_W = 4;
    localparam int LSB_W   = 3;

    logic               i_Clk = 1'b0;
    logic               i_Rst;
    logic               i_Valid;
    logic               o_Ready;
    logic [WIDTH-1:0]   i_A;
    logic [WIDTH-1:0]   i_B;
    logic [2:0]         i_Op;
    logic [LSB_W-1:0]   i_Lsb;
    logic               o_Valid;
    logic               i_Ready;
    logic [WIDTH-1:0]   o_Result;
    logic [FIELD_W-1:0] o_Field;
    logic               o_Zero;
`ifdef REDUCE_FLAGS_EN
    logic               o_RedAnd;
    logic               o_RedOr;
    logic               o_RedXor;
`endif

    typedef struct {
        logic [WIDTH-1:0]   res;
        logic [FIELD_W-1:0] field;
        logic               zero;
        int                 due;
    } beat_t;

    beat_t q[$];
    int    cyc        = 0;
    int    checkCount = 0;
    int    passCount  = 0;

    always #5 i_Clk = ~i_Clk;

    bitwise_logic_stage #(
        .WIDTH   (WIDTH),
        .FIELD_W (FIELD_W)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Valid  (i_Valid),
        .o_Ready  (o_Ready),
        .i_A      (i_A),
        .i_B      (i_B),
        .i_Op     (i_Op),
        .i_Lsb    (i_Lsb),
        .o_Valid  (o_Valid),
        .i_Ready  (i_Ready),
        .o_Result (o_Result),
        .o_Field  (o_Field),
`ifdef REDUCE_FLAGS_EN
        .o_RedAnd (o_RedAnd),
        .o_RedOr  (o_RedOr),
        .o_RedXor (o_RedXor),
`endif
        .o_Zero   (o_Zero)
    );

    // Reference logic operation written straight from the opcode table
    function automatic logic [WIDTH-1:0] refOp(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op, input logic [LSB_W-1:0] lsb, input logic rdy,
                                 output logic acc);
        logic  expValid;
        logic  expReady;
        beat_t nb;
        logic [WIDTH-1:0] r;
        @(negedge i_Clk);
        i_Rst   = 1'b0;
        i_Valid = v;
        i_A     = a;
        i_B     = b;
        i_Op    = op;
        i_Lsb   = lsb;
        i_Ready = rdy;
        #1;
        expValid = (q.size() > 0) && (q[0].due <= cyc);
        expReady = (q.size() < 2) || rdy;
        checkOutput("o_Valid", 32'(o_Valid), 32'(expValid));
        checkOutput("o_Ready", 32'(o_Ready), 32'(expReady));
        if (expValid) begin
            checkOutput("o_Result", 32'(o_Result), 32'(q[0].res));
            checkOutput("o_Field",  32'(o_Field),  32'(q[0].field));
            checkOutput("o_Zero",   32'(o_Zero),   32'(q[0].zero));
`ifdef REDUCE_FLAGS_EN
            checkOutput("o_RedAnd", 32'(o_RedAnd), 32'(q[0].res == {WIDTH{1'b1}}));
            checkOutput("o_RedOr",  32'(o_RedOr),  32'(q[0].res != '0));
            checkOutput("o_RedXor", 32'(o_RedXor), 32'($countones(q[0].res) % 2));
`endif
        end
        if (expValid && rdy) void'(q.pop_front());
        acc = v && expReady;
        if (acc) begin
            r        = refOp(op, a, b);
            nb.res   = r;
            nb.field = FIELD_W'((int'(r) / (2 ** int'(lsb))) % (2 ** FIELD_W));
            nb.zero  = (r == '0);
            nb.due   = cyc + 2;
            q.push_back(nb);
        end
        @(posedge i_Clk);
        cyc++;
    endtask

    // One-cycle synchronous reset, then check the reset state
    task automatic applyReset();
        @(negedge i_Clk);
        i_Rst   = 1'b1;
        i_Valid = 1'b0;
        i_Ready = 1'b0;
        @(posedge i_Clk);
        cyc++;
        @(negedge i_Clk);
        #1;
        checkOutput("rst o_Valid",  32'(o_Valid),  32'd0);
        checkOutput("rst o_Zero",   32'(o_Zero),   32'd1);
        checkOutput("rst o_Result", 32'(o_Result), 32'd0);
        checkOutput("rst o_Field",  32'(o_Field),  32'd0);
        checkOutput("rst o_Ready",  32'(o_Ready),  32'd1);
`ifdef REDUCE_FLAGS_EN
        checkOutput("rst o_RedOr",  32'(o_RedOr),  32'd0);
`endif
        i_Rst = 1'b0;
        q.delete();
        @(posedge i_Clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 3'd0, '0, rdy, acc);
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] stallA[3];
        int               k;

        i_Rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0;
        i_A = '0; i_B = '0; i_Op = '0; i_Lsb = '0;
        repeat (2) @(posedge i_Clk);
        applyReset();

        // Single AND beat, then OR/XOR/NOT A back to back
        applyStimulus(1'b1, 8'h05, 8'h0C, 3'd0, 3'd0, 1'b1, acc);
        idle(3, 1'b1);
        applyStimulus(1'b1, 8'h05, 8'h0C, 3'd1, 3'd0, 1'b1, acc);
        applyStimulus(1'b1, 8'h05, 8'h0C, 3'd2, 3'd0, 1'b1, acc);
        applyStimulus(1'b1, 8'h05, 8'h0C, 3'd3, 3'd1, 1'b1, acc);
        idle(4, 1'b1);

        // Field extraction including a field running past the MSB
        applyStimulus(1'b1, 8'hDF, 8'h00, 3'd7, 3'd2, 1'b1, acc);
        applyStimulus(1'b1, 8'hDF, 8'h00, 3'd7, 3'd6, 1'b1, acc);
        applyStimulus(1'b1, 8'hDF, 8'h00, 3'd7, 3'd7, 1'b1, acc);
        idle(4, 1'b1);

        // Downstream stall for 5 cycles while 3 beats are offered
        stallA[0] = 8'h11; stallA[1] = 8'h22; stallA[2] = 8'h33;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(k < 3, (k < 3) ? stallA[k] : 8'h00, 8'hF0, 3'd7, 3'd4, 1'b0, acc);
            if (acc) k++;
        end
        checkOutput("stall accepts", 32'(k), 32'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(k < 3, (k < 3) ? stallA[k] : 8'h00, 8'hF0, 3'd7, 3'd4, 1'b1, acc);
            if (acc) k++;
        end
        checkOutput("stall drained", 32'(q.size()), 32'd0);

        // Reset with two beats in flight; nothing stale may appear afterwards
        applyStimulus(1'b1, 8'hA5, 8'h5A, 3'd2, 3'd0, 1'b1, acc);
        applyStimulus(1'b1, 8'h3C, 8'hFF, 3'd4, 3'd0, 1'b1, acc);
        applyReset();
        idle(5, 1'b1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), WIDTH'($urandom), WIDTH'($urandom),
                          3'($urandom_range(0, 7)), LSB_W'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) < 6), acc);
        end
        idle(6, 1'b1);
        checkOutput("final drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
